// File: rtl/pio_input_debouncer.sv
// Input conditioner for the edge-capture PIO. Each channel is synchronised, optionally inverted,
// then filtered on a shared prescaled tick. Clean levels and one-cycle change strobes are presented.
module pio_input_debouncer #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      TICK_DIV     = 50000,
  parameter int unsigned      STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] INVERT_MASK  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] change_pulse,
  output logic             any_change,
  output logic             tick
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, norm;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

  // Synchronisers reset to the inactive raw level so release of reset reads as idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= INVERT_MASK;
      sync2_q <= INVERT_MASK;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign norm = sync2_q ^ INVERT_MASK;

  // Tick is registered from the next count so it is high while the count sits at DivMax.
  always_comb begin
    div_d  = (div_q == DivMax) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DivMax);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // Any cycle back at the current level restarts that channel's count.
  always_comb begin
    data_d  = data_q;
    pulse_d = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (norm[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CntMax) begin
          data_d[i]  = norm[i];
          cnt_d[i]   = '0;
          pulse_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out     = data_q;
  assign change_pulse = pulse_q;
  assign any_change   = |pulse_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Directed bench for pio_input_debouncer with TICK_DIV=4, STABLE_TICKS=3, INVERT_MASK=16'h000F.
module tb_pio_input_debouncer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] raw_in;
  logic [15:0] data_out;
  logic [15:0] change_pulse;
  logic        any_change;
  logic        tick;

  pio_input_debouncer #(
    .WIDTH       (16),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .INVERT_MASK (16'h000F)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .data_out    (data_out),
    .change_pulse(change_pulse),
    .any_change  (any_change),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-window observation state; edge_no counts edges since clear_stats.
  int          edge_no;
  logic [15:0] prev_data;
  logic [15:0] last_pulse;
  int          rise_cnt[16];
  int          fall_cnt[16];
  int          pulse_cnt[16];
  int          first_flip[16];
  int          total_pulses;
  int          pulse_bad;
  int          any_cnt;
  int          any_bad;

  task automatic clear_stats();
    edge_no      = 0;
    prev_data    = data_out;
    last_pulse   = '0;
    total_pulses = 0;
    pulse_bad    = 0;
    any_cnt      = 0;
    any_bad      = 0;
    for (int i = 0; i < 16; i++) begin
      rise_cnt[i]   = 0;
      fall_cnt[i]   = 0;
      pulse_cnt[i]  = 0;
      first_flip[i] = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    for (int i = 0; i < 16; i++) begin
      if (data_out[i] && !prev_data[i]) rise_cnt[i]++;
      if (!data_out[i] && prev_data[i]) fall_cnt[i]++;
      if (data_out[i] != prev_data[i] && first_flip[i] < 0) first_flip[i] = edge_no;
      if (change_pulse[i]) begin
        pulse_cnt[i]++;
        total_pulses++;
      end
    end
    if (change_pulse != (data_out ^ prev_data)) pulse_bad++;
    if (any_change != (change_pulse != 16'h0)) any_bad++;
    if (any_change) any_cnt++;
    if (change_pulse != 16'h0) last_pulse = change_pulse;
    prev_data = data_out;
  endtask

  function automatic logic [31:0] in_window(input int e);
    return (e >= 11 && e <= 14) ? 32'd1 : 32'd0;
  endfunction

  int          n_ticks;
  int          first_tick;
  int          last_tick;
  int          bad_period;
  logic [15:0] seen_data;
  logic [15:0] seen_pulse;

  initial begin
    // 1: reset with all inputs idle; outputs quiet, tick period 4
    reset_n = 1'b0;
    raw_in  = 16'h000F;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_reset_data", 32'(data_out), 32'h0);
    check_eq("t1_reset_pulse", 32'(change_pulse), 32'h0);
    check_eq("t1_reset_tick", 32'(tick), 32'h0);
    reset_n    = 1'b1;
    n_ticks    = 0;
    first_tick = -1;
    last_tick  = -1;
    bad_period = 0;
    seen_data  = '0;
    seen_pulse = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      seen_data  = seen_data | data_out;
      seen_pulse = seen_pulse | change_pulse;
      if (tick) begin
        if (last_tick >= 0 && (c - last_tick) != 4) bad_period++;
        if (first_tick < 0) first_tick = c;
        last_tick = c;
        n_ticks++;
      end
    end
    check_eq("t1_idle_data", 32'(seen_data), 32'h0);
    check_eq("t1_idle_pulse", 32'(seen_pulse), 32'h0);
    check_eq("t1_first_tick", 32'(first_tick), 32'd3);
    check_eq("t1_tick_count", 32'(n_ticks), 32'd25);
    check_eq("t1_tick_period", 32'(bad_period), 32'd0);

    // 2: active-low press on channel 0
    clear_stats();
    raw_in[0] = 1'b0;
    repeat (20) step();
    check_eq("t2_flip_in_window", in_window(first_flip[0]), 32'd1);
    check_eq("t2_data", 32'(data_out), 32'h0001);
    check_eq("t2_pulse_count", 32'(pulse_cnt[0]), 32'd1);
    check_eq("t2_total_pulses", 32'(total_pulses), 32'd1);
    check_eq("t2_pulse_matches_flip", 32'(pulse_bad), 32'd0);

    // 3: 6-cycle glitch on channel 4 is filtered out
    clear_stats();
    raw_in[4] = 1'b1;
    repeat (6) step();
    raw_in[4] = 1'b0;
    repeat (30) step();
    check_eq("t3_data4", 32'(data_out[4]), 32'h0);
    check_eq("t3_rise4", 32'(rise_cnt[4]), 32'd0);
    check_eq("t3_pulse4", 32'(pulse_cnt[4]), 32'd0);

    // 4: bouncing channel 5, then held high, then released
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      raw_in[5] = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    raw_in[5] = 1'b1;
    repeat (30) step();
    check_eq("t4_data5_high", 32'(data_out[5]), 32'h1);
    check_eq("t4_rise5", 32'(rise_cnt[5]), 32'd1);
    check_eq("t4_fall5", 32'(fall_cnt[5]), 32'd0);
    check_eq("t4_pulse5", 32'(pulse_cnt[5]), 32'd1);
    clear_stats();
    raw_in[5] = 1'b0;
    repeat (20) step();
    check_eq("t4_data5_low", 32'(data_out[5]), 32'h0);
    check_eq("t4_fall5_release", 32'(fall_cnt[5]), 32'd1);
    check_eq("t4_pulse5_release", 32'(pulse_cnt[5]), 32'd1);
    check_eq("t4_release_in_window", in_window(first_flip[5]), 32'd1);

    // 5: release channel 0 first, then simultaneous press on 0 and 15
    raw_in[0] = 1'b1;
    repeat (20) step();
    check_eq("t5_prep_data", 32'(data_out), 32'h0000);
    clear_stats();
    raw_in[15] = 1'b1;
    raw_in[0]  = 1'b0;
    repeat (20) step();
    check_eq("t5_data", 32'(data_out), 32'h8001);
    check_eq("t5_same_edge", 32'(first_flip[15] == first_flip[0]), 32'd1);
    check_eq("t5_pulse_vector", 32'(last_pulse), 32'h8001);
    check_eq("t5_total_pulses", 32'(total_pulses), 32'd2);
    check_eq("t5_any_change_cycles", 32'(any_cnt), 32'd1);
    check_eq("t5_any_change_or", 32'(any_bad), 32'd0);

    // 6: reset mid-count on channel 6; full latency required again
    clear_stats();
    raw_in[6] = 1'b1;
    repeat (10) step();
    check_eq("t6_pending_data6", 32'(data_out[6]), 32'h0);
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_data", 32'(data_out), 32'h0);
    check_eq("t6_async_pulse", 32'(change_pulse), 32'h0);
    check_eq("t6_async_tick", 32'(tick), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_held_pulse", 32'(change_pulse), 32'h0);
    reset_n = 1'b1;
    clear_stats();
    repeat (20) step();
    check_eq("t6_flip6_in_window", in_window(first_flip[6]), 32'd1);
    check_eq("t6_flip0_in_window", in_window(first_flip[0]), 32'd1);
    check_eq("t6_data", 32'(data_out), 32'h8041);
    check_eq("t6_pulse6", 32'(pulse_cnt[6]), 32'd1);
    check_eq("t6_total_pulses", 32'(total_pulses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
